// File: rtl/branch_resolve_ctrl.sv
// Branch resolution controller: in-order FIFO of predicted branches, compared
// against EX outcomes to produce predictor training requests and fetch redirects.
module branch_resolve_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pred_valid,
  input  logic [31:0]              pred_pc,
  input  logic                     pred_taken,
  input  logic [31:0]              pred_target,
  output logic                     pred_ready,
  input  logic                     res_valid,
  input  logic                     res_taken,
  input  logic [31:0]              res_target,
  output logic                     res_ready,
  output logic                     upd_valid,
  output logic [31:0]              upd_pc,
  output logic                     upd_taken,
  input  logic                     upd_ready,
  output logic                     redirect_valid,
  output logic [31:0]              redirect_pc,
  output logic                     flush,
  output logic [$clog2(DEPTH):0]   inflight_cnt,
  output logic [15:0]              mispredict_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ZERO = (AW+1)'(0);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  typedef enum logic {RUN = 1'b0, WAIT_UPD = 1'b1} state_t;

  state_t        state_r;
  logic [31:0]   pc_mem_r    [DEPTH];
  logic          taken_mem_r [DEPTH];
  logic [31:0]   tgt_mem_r   [DEPTH];
  logic [AW-1:0] head_r;
  logic [AW-1:0] tail_r;
  logic [AW:0]   count_r;

  logic [31:0]   head_pc_s;
  logic          head_taken_s;
  logic [31:0]   head_tgt_s;
  logic          pop_s;
  logic          push_s;
  logic          mispredict_s;
  logic [31:0]   fix_pc_s;

  assign pred_ready   = (count_r != CNT_FULL);
  assign res_ready    = (state_r == RUN) && (count_r != CNT_ZERO);
  assign inflight_cnt = count_r;

  // Head lookup, mispredict detection and push/pop qualification.
  always_comb begin
    head_pc_s    = pc_mem_r[head_r];
    head_taken_s = taken_mem_r[head_r];
    head_tgt_s   = tgt_mem_r[head_r];
    pop_s        = res_valid && res_ready;
    if (pop_s) begin
      mispredict_s = (head_taken_s != res_taken) ||
                     (res_taken && (head_tgt_s != res_target));
    end else begin
      mispredict_s = 1'b0;
    end
    // Entries younger than a mispredicted branch are wrong-path, including one arriving now.
    push_s   = pred_valid && pred_ready && !mispredict_s;
    fix_pc_s = res_taken ? res_target : (head_pc_s + 32'd4);
  end

  // Branch entry storage, written at the tail on every accepted push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_r[i]    <= 32'd0;
        taken_mem_r[i] <= 1'b0;
        tgt_mem_r[i]   <= 32'd0;
      end
    end else if (push_s) begin
      pc_mem_r[tail_r]    <= pred_pc;
      taken_mem_r[tail_r] <= pred_taken;
      tgt_mem_r[tail_r]   <= pred_target;
    end
  end

  // FIFO pointers/occupancy, update handshake FSM, redirect pulses and statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= RUN;
      head_r         <= '0;
      tail_r         <= '0;
      count_r        <= CNT_ZERO;
      upd_valid      <= 1'b0;
      upd_pc         <= 32'd0;
      upd_taken      <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'd0;
      flush          <= 1'b0;
      mispredict_cnt <= 16'd0;
    end else begin
      flush          <= mispredict_s;
      redirect_valid <= mispredict_s;
      if (mispredict_s) begin
        redirect_pc <= fix_pc_s;
        head_r      <= '0;
        tail_r      <= '0;
        count_r     <= CNT_ZERO;
        if (mispredict_cnt != 16'hFFFF) begin
          mispredict_cnt <= mispredict_cnt + 16'd1;
        end
      end else begin
        if (push_s) begin
          tail_r <= tail_r + PTR_ONE;
        end
        if (pop_s) begin
          head_r <= head_r + PTR_ONE;
        end
        case ({push_s, pop_s})
          2'b10:   count_r <= count_r + CNT_ONE;
          2'b01:   count_r <= count_r - CNT_ONE;
          default: count_r <= count_r;
        endcase
      end

      case (state_r)
        RUN: begin
          if (pop_s) begin
            upd_valid <= 1'b1;
            upd_pc    <= head_pc_s;
            upd_taken <= res_taken;
            state_r   <= WAIT_UPD;
          end
        end
        WAIT_UPD: begin
          if (upd_ready) begin
            upd_valid <= 1'b0;
            state_r   <= RUN;
          end
        end
        default: begin
          upd_valid <= 1'b0;
          state_r   <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl: directed vector table, hand-written
// backpressure/reset sequences, and randomized traffic against a queue-based model.
module tb_branch_resolve_ctrl;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        pred_valid;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        pred_ready;
  logic        res_valid;
  logic        res_taken;
  logic [31:0] res_target;
  logic        res_ready;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic        upd_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic [$clog2(DEPTH):0] inflight_cnt;
  logic [15:0] mispredict_cnt;

  int checks = 0;
  int errors = 0;

  branch_resolve_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .pred_target(pred_target), .pred_ready(pred_ready),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .res_ready(res_ready),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_ready(upd_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
    .inflight_cnt(inflight_cnt), .mispredict_cnt(mispredict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  typedef struct {
    logic        pv; logic [31:0] ppc; logic pt; logic [31:0] ptg;
    logic        rv; logic rt; logic [31:0] rtg; logic ur;
    int          e_cnt; logic e_fl; logic e_rdv; logic [31:0] e_rpc;
    logic        e_uv; logic [31:0] e_upc; logic e_ut; int e_mc;
  } vec_t;

  typedef struct { logic [31:0] pc; logic taken; logic [31:0] target; } ent_t;

  // Behavioural reference state
  ent_t        mq[$];
  bit          m_wait;
  logic        m_uv, m_ut, m_fl;
  logic [31:0] m_upc, m_rpc;
  int          m_mc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic pv, input logic [31:0] ppc, input logic pt,
                       input logic [31:0] ptg, input logic rv, input logic rt,
                       input logic [31:0] rtg, input logic ur);
    pred_valid = pv; pred_pc = ppc; pred_taken = pt; pred_target = ptg;
    res_valid = rv; res_taken = rt; res_target = rtg; upd_ready = ur;
  endtask

  function automatic vec_t mk(logic pv, logic [31:0] ppc, logic pt, logic [31:0] ptg,
                              logic rv, logic rt, logic [31:0] rtg, logic ur,
                              int ec, logic efl, logic erdv, logic [31:0] erpc,
                              logic euv, logic [31:0] eupc, logic eut, int emc);
    vec_t v;
    v.pv = pv; v.ppc = ppc; v.pt = pt; v.ptg = ptg;
    v.rv = rv; v.rt = rt; v.rtg = rtg; v.ur = ur;
    v.e_cnt = ec; v.e_fl = efl; v.e_rdv = erdv; v.e_rpc = erpc;
    v.e_uv = euv; v.e_upc = eupc; v.e_ut = eut; v.e_mc = emc;
    return v;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_wait = 0; m_uv = 0; m_ut = 0; m_fl = 0; m_upc = 32'd0; m_rpc = 32'd0; m_mc = 0;
  endtask

  // One clock of the architectural rules, evaluated from the inputs present before the edge.
  task automatic model_step();
    bit   prdy, rrdy, acc, mis;
    ent_t h;
    prdy = (mq.size() != DEPTH);
    rrdy = !m_wait && (mq.size() != 0);
    acc  = res_valid && rrdy;
    mis  = 0;
    h    = '{32'd0, 1'b0, 32'd0};
    if (acc) begin
      h   = mq[0];
      mis = (h.taken != res_taken) || (res_taken && (h.target != res_target));
    end
    m_fl = mis;
    if (mis) m_rpc = res_taken ? res_target : h.pc + 32'd4;
    if (m_wait) begin
      if (upd_ready) begin m_uv = 0; m_wait = 0; end
    end else if (acc) begin
      m_uv = 1; m_upc = h.pc; m_ut = res_taken; m_wait = 1;
    end
    if (mis) begin
      mq.delete();
      if (m_mc < 65535) m_mc++;
    end else begin
      if (acc) void'(mq.pop_front());
      if (pred_valid && prdy) mq.push_back('{pred_pc, pred_taken, pred_target});
    end
  endtask

  task automatic compare_model(input int cyc);
    chk($sformatf("r%0d_cnt", cyc), 32'(inflight_cnt), 32'(mq.size()));
    chk($sformatf("r%0d_pred_ready", cyc), 32'(pred_ready), 32'(mq.size() != DEPTH));
    chk($sformatf("r%0d_res_ready", cyc), 32'(res_ready), 32'(!m_wait && mq.size() != 0));
    chk($sformatf("r%0d_upd_valid", cyc), 32'(upd_valid), 32'(m_uv));
    chk($sformatf("r%0d_upd_pc", cyc), upd_pc, m_upc);
    chk($sformatf("r%0d_upd_taken", cyc), 32'(upd_taken), 32'(m_ut));
    chk($sformatf("r%0d_flush", cyc), 32'(flush), 32'(m_fl));
    chk($sformatf("r%0d_redir_valid", cyc), 32'(redirect_valid), 32'(m_fl));
    chk($sformatf("r%0d_redir_pc", cyc), redirect_pc, m_rpc);
    chk($sformatf("r%0d_mcnt", cyc), 32'(mispredict_cnt), 32'(m_mc));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_cnt"}, 32'(inflight_cnt), 32'd0);
    chk({tag, "_upd_valid"}, 32'(upd_valid), 32'd0);
    chk({tag, "_upd_pc"}, upd_pc, 32'd0);
    chk({tag, "_upd_taken"}, 32'(upd_taken), 32'd0);
    chk({tag, "_redir_valid"}, 32'(redirect_valid), 32'd0);
    chk({tag, "_redir_pc"}, redirect_pc, 32'd0);
    chk({tag, "_flush"}, 32'(flush), 32'd0);
    chk({tag, "_mcnt"}, 32'(mispredict_cnt), 32'd0);
    chk({tag, "_res_ready"}, 32'(res_ready), 32'd0);
    chk({tag, "_pred_ready"}, 32'(pred_ready), 32'd1);
  endtask

  vec_t vecs[18];

  initial begin
    // pv ppc pt ptg | rv rt rtg ur | cnt fl rdv rpc uv upc ut mc
    vecs[0]  = mk(1, 32'h100, 1, 32'h200, 0, 0, 32'h0,   1, 1, 0, 0, 32'h0,   0, 32'h0,   0, 0);
    vecs[1]  = mk(0, 32'h0,   0, 32'h0,   1, 1, 32'h200, 1, 0, 0, 0, 32'h0,   1, 32'h100, 1, 0);
    vecs[2]  = mk(0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   1, 0, 0, 0, 32'h0,   0, 32'h100, 1, 0);
    vecs[3]  = mk(1, 32'h40,  0, 32'h0,   0, 0, 32'h0,   1, 1, 0, 0, 32'h0,   0, 32'h100, 1, 0);
    vecs[4]  = mk(1, 32'h44,  1, 32'h80,  0, 0, 32'h0,   1, 2, 0, 0, 32'h0,   0, 32'h100, 1, 0);
    vecs[5]  = mk(0, 32'h0,   0, 32'h0,   1, 1, 32'h300, 1, 0, 1, 1, 32'h300, 1, 32'h40,  1, 1);
    vecs[6]  = mk(0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   1, 0, 0, 0, 32'h300, 0, 32'h40,  1, 1);
    vecs[7]  = mk(1, 32'h10,  1, 32'h20,  0, 0, 32'h0,   1, 1, 0, 0, 32'h300, 0, 32'h40,  1, 1);
    vecs[8]  = mk(0, 32'h0,   0, 32'h0,   1, 1, 32'h24,  1, 0, 1, 1, 32'h24,  1, 32'h10,  1, 2);
    vecs[9]  = mk(0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   1, 0, 0, 0, 32'h24,  0, 32'h10,  1, 2);
    vecs[10] = mk(1, 32'hFFFFFFFC, 1, 32'h1000, 0, 0, 32'h0, 1, 1, 0, 0, 32'h24, 0, 32'h10, 1, 2);
    vecs[11] = mk(0, 32'h0,   0, 32'h0,   1, 0, 32'h0,   1, 0, 1, 1, 32'h0,   1, 32'hFFFFFFFC, 0, 3);
    vecs[12] = mk(0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   1, 0, 0, 0, 32'h0,   0, 32'hFFFFFFFC, 0, 3);
    vecs[13] = mk(1, 32'h500, 0, 32'h0,   0, 0, 32'h0,   1, 1, 0, 0, 32'h0,   0, 32'hFFFFFFFC, 0, 3);
    vecs[14] = mk(1, 32'h504, 0, 32'h0,   1, 0, 32'h0,   1, 1, 0, 0, 32'h0,   1, 32'h500, 0, 3);
    vecs[15] = mk(1, 32'h508, 1, 32'h600, 1, 1, 32'h777, 1, 2, 0, 0, 32'h0,   0, 32'h500, 0, 3);
    vecs[16] = mk(1, 32'h50C, 0, 32'h0,   1, 1, 32'h999, 1, 0, 1, 1, 32'h999, 1, 32'h504, 1, 4);
    vecs[17] = mk(0, 32'h0,   0, 32'h0,   1, 1, 32'h123, 1, 0, 0, 0, 32'h999, 0, 32'h504, 1, 4);

    rst = 1'b1;
    drive(0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0);
    #12;
    check_all_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].pv, vecs[i].ppc, vecs[i].pt, vecs[i].ptg,
            vecs[i].rv, vecs[i].rt, vecs[i].rtg, vecs[i].ur);
      tick();
      chk($sformatf("v%0d_cnt", i), 32'(inflight_cnt), 32'(vecs[i].e_cnt));
      chk($sformatf("v%0d_flush", i), 32'(flush), 32'(vecs[i].e_fl));
      chk($sformatf("v%0d_redir_valid", i), 32'(redirect_valid), 32'(vecs[i].e_rdv));
      chk($sformatf("v%0d_redir_pc", i), redirect_pc, vecs[i].e_rpc);
      chk($sformatf("v%0d_upd_valid", i), 32'(upd_valid), 32'(vecs[i].e_uv));
      chk($sformatf("v%0d_upd_pc", i), upd_pc, vecs[i].e_upc);
      chk($sformatf("v%0d_upd_taken", i), 32'(upd_taken), 32'(vecs[i].e_ut));
      chk($sformatf("v%0d_mcnt", i), 32'(mispredict_cnt), 32'(vecs[i].e_mc));
    end

    // Fill to capacity with the predictor stalled
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h1000 + 32'(4 * i), 0, 32'h0, 0, 0, 32'h0, 0);
      tick();
      chk($sformatf("fill%0d_cnt", i), 32'(inflight_cnt), 32'(i + 1));
    end
    chk("full_pred_ready", 32'(pred_ready), 32'd0);
    drive(1, 32'h2000, 0, 32'h0, 0, 0, 32'h0, 0);
    tick();
    chk("full_push_cnt", 32'(inflight_cnt), 32'd4);
    drive(0, 32'h0, 0, 32'h0, 1, 0, 32'h0, 0);
    tick();
    chk("bp_res_cnt", 32'(inflight_cnt), 32'd3);
    chk("bp_res_upd_valid", 32'(upd_valid), 32'd1);
    chk("bp_res_upd_pc", upd_pc, 32'h1000);
    for (int i = 0; i < 5; i++) begin
      drive(0, 32'h0, 0, 32'h0, 1, 1, 32'h5555, 0);
      tick();
      chk($sformatf("bp%0d_res_ready", i), 32'(res_ready), 32'd0);
      chk($sformatf("bp%0d_upd_valid", i), 32'(upd_valid), 32'd1);
      chk($sformatf("bp%0d_upd_pc", i), upd_pc, 32'h1000);
      chk($sformatf("bp%0d_upd_taken", i), 32'(upd_taken), 32'd0);
      chk($sformatf("bp%0d_cnt", i), 32'(inflight_cnt), 32'd3);
      chk($sformatf("bp%0d_flush", i), 32'(flush), 32'd0);
    end
    drive(0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 1);
    tick();
    chk("bp_release_upd_valid", 32'(upd_valid), 32'd0);
    chk("bp_release_res_ready", 32'(res_ready), 32'd1);

    // Push alongside a correct resolve, then reset while waiting on the predictor
    drive(1, 32'h3000, 0, 32'h0, 1, 0, 32'h0, 0);
    tick();
    chk("sim_cnt", 32'(inflight_cnt), 32'd3);
    chk("sim_upd_pc", upd_pc, 32'h1004);
    chk("sim_upd_valid", 32'(upd_valid), 32'd1);
    chk("sim_flush", 32'(flush), 32'd0);
    drive(0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0);
    #2 rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    drive(0, 32'h0, 0, 32'h0, 1, 1, 32'h4444, 1);
    #2 rst = 1'b0;
    tick();
    chk("post_rst_cnt", 32'(inflight_cnt), 32'd0);
    chk("post_rst_upd_valid", 32'(upd_valid), 32'd0);
    chk("post_rst_flush", 32'(flush), 32'd0);
    chk("post_rst_mcnt", 32'(mispredict_cnt), 32'd0);

    // Randomized traffic against the reference model
    drive(0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0);
    rst = 1'b1;
    #2 rst = 1'b0;
    model_reset();
    for (int c = 0; c < 2000; c++) begin
      logic [31:0] ppc;
      ppc = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFC : ($urandom() & 32'hFFFFFFFC);
      drive($urandom_range(0, 9) < 7, ppc, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 1) != 0) ? 32'h200 : 32'h300,
            $urandom_range(0, 9) < 4, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 1) != 0) ? 32'h200 : 32'h300,
            1'($urandom_range(0, 1)));
      model_step();
      tick();
      compare_model(c);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve_ctrl.md
BRANCH_RESOLVE_CTRL -- requirements
Module: branch_resolve_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of in-flight branch entries (power of 2, range 2..16).
REQ-002 SHALL have port clk, input, 1, system clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port pred_valid, input, 1, meaning fetch records a predicted branch.
REQ-005 SHALL have port pred_pc, input, 32, meaning the branch PC.
REQ-006 SHALL have port pred_taken, input, 1, meaning the predicted direction.
REQ-007 SHALL have port pred_target, input, 32, meaning the predicted target.
REQ-008 SHALL have port pred_ready, output, 1, meaning the FIFO is not full.
REQ-009 SHALL have port res_valid, input, 1, meaning EX resolves the oldest branch.
REQ-010 SHALL have port res_taken, input, 1, meaning the actual direction.
REQ-011 SHALL have port res_target, input, 32, meaning the actual target.
REQ-012 SHALL have port res_ready, output, 1, meaning a resolve can be accepted.
REQ-013 SHALL have port upd_valid, output, 1, meaning a predictor training request.
REQ-014 SHALL have port upd_pc, output, 32, meaning the PC of the branch being trained.
REQ-015 SHALL have port upd_taken, output, 1, meaning the actual outcome to train with.
REQ-016 SHALL have port upd_ready, input, 1, meaning the predictor accepts the update.
REQ-017 SHALL have port redirect_valid, output, 1, meaning a one-cycle fetch redirect pulse.
REQ-018 SHALL have port redirect_pc, output, 32, meaning the corrected fetch PC.
REQ-019 SHALL have port flush, output, 1, meaning a one-cycle wrong-path flush pulse.
REQ-020 SHALL have port inflight_cnt, output, $clog2(DEPTH)+1, meaning the number of occupied entries.
REQ-021 SHALL have port mispredict_cnt, output, 16, meaning the count of mispredictions.

Function
REQ-022 SHALL hold in-order entries {pc, taken, target}; push on pred_valid&&pred_ready; pop head on res_valid&&res_ready.
REQ-023 SHALL drive pred_ready = (inflight_cnt != DEPTH), combinationally.
REQ-024 SHALL implement states RUN and WAIT_UPD, where res_ready = (state==RUN) && (inflight_cnt!=0).
REQ-025 SHALL declare a mispredict when head.taken != res_taken, or when both are taken and head.target != res_target.
REQ-026 SHALL, on an accepted resolve, register upd_pc=head.pc and upd_taken=res_taken, assert upd_valid from the next cycle, and enter WAIT_UPD.
REQ-027 SHALL, in WAIT_UPD, hold upd_valid/upd_pc/upd_taken stable until upd_ready, then deassert upd_valid and return to RUN on the same edge; pushes remain allowed.
REQ-028 SHALL, on an accepted mispredicting resolve, assert flush and redirect_valid for exactly one cycle (the cycle after acceptance).
REQ-029 SHALL set redirect_pc = res_taken ? res_target : head.pc+4, with 32-bit wrap-around.
REQ-030 SHALL, on that same mispredict edge, empty the FIFO (inflight_cnt=0), since all younger entries are wrong-path.
REQ-031 SHALL discard a push coinciding with a mispredicting resolve.
REQ-032 SHALL, on a push coinciding with a correct resolve, perform both (count unchanged).
REQ-033 SHALL ignore res_valid while res_ready=0 (FIFO empty or WAIT_UPD), with no state change.
REQ-034 SHALL increment mispredict_cnt by 1 per mispredict, saturating at 16'hFFFF.
REQ-035 SHALL register redirect_valid, redirect_pc, flush, upd_*, and mispredict_cnt.

Reset
REQ-036 SHALL, on rst, immediately set state=RUN, FIFO empty, inflight_cnt=0, upd_valid=0, upd_pc=0, upd_taken=0, redirect_valid=0, redirect_pc=0, flush=0, mispredict_cnt=0.
REQ-037 SHALL abort a reset asserted in WAIT_UPD or mid-pulse without completing the pending update or pulse.

Verification
REQ-038 SHALL verify correct prediction: push {0x100,1,0x200}, resolve taken 0x200 -> no flush; upd_valid with upd_pc=0x100, upd_taken=1; count 0.
REQ-039 SHALL verify direction mispredict: push {0x40,0,x}, {0x44,1,0x80}, resolve not-taken vs taken 0x300 on 0x40 -> flush=1 and redirect 0x300 for 1 cycle; inflight_cnt=0; mispredict_cnt=1.
REQ-040 SHALL verify target mispredict: push {0x10,1,0x20}, resolve taken 0x24 -> redirect_pc=0x24; not-taken mispredict on pc 0xFFFFFFFC -> redirect_pc=0x0.
REQ-041 SHALL verify full/backpressure: push 4 entries -> pred_ready=0; hold upd_ready=0 after a resolve -> res_ready=0, upd fields stable 5 cycles; upd_ready=1 -> RUN.
REQ-042 SHALL verify simultaneous events: a push concurrent with a correct resolve leaves the count unchanged; a push concurrent with a mispredict is dropped (count 0).
REQ-043 SHALL verify reset mid-operation: rst during WAIT_UPD with 3 entries -> all outputs 0 asynchronously; res_valid on empty FIFO is ignored.
